// File: rtl/dm_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: DM operation codes, FSM state
// codes and the last-winner encoding.
package dm_arbiter_pkg;

  // DM operation: op[0] is the write enable, op[3:1] the access width.
  localparam int DMOP_SIZE = 4;

  // Width codes are non-zero so that a word load never aliases the idle NOP.
  localparam logic [2:0] DMOP_WD_WORD  = 3'd1;
  localparam logic [2:0] DMOP_WD_BYTE  = 3'd2;
  localparam logic [2:0] DMOP_WD_HALF  = 3'd3;
  localparam logic [2:0] DMOP_WD_BYTEU = 3'd4;
  localparam logic [2:0] DMOP_WD_HALFU = 3'd5;

  localparam logic [DMOP_SIZE-1:0] DMOP_NOP = '0;
  localparam logic [DMOP_SIZE-1:0] DMOP_LW  = {DMOP_WD_WORD,  1'b0};
  localparam logic [DMOP_SIZE-1:0] DMOP_SW  = {DMOP_WD_WORD,  1'b1};
  localparam logic [DMOP_SIZE-1:0] DMOP_LB  = {DMOP_WD_BYTE,  1'b0};
  localparam logic [DMOP_SIZE-1:0] DMOP_SB  = {DMOP_WD_BYTE,  1'b1};
  localparam logic [DMOP_SIZE-1:0] DMOP_LH  = {DMOP_WD_HALF,  1'b0};
  localparam logic [DMOP_SIZE-1:0] DMOP_SH  = {DMOP_WD_HALF,  1'b1};
  localparam logic [DMOP_SIZE-1:0] DMOP_LBU = {DMOP_WD_BYTEU, 1'b0};
  localparam logic [DMOP_SIZE-1:0] DMOP_LHU = {DMOP_WD_HALFU, 1'b0};

  // Arbiter FSM state codes.
  localparam logic [0:0] DMARB_OPEN = 1'b0;
  localparam logic [0:0] DMARB_LOCK = 1'b1;

  typedef enum logic {
    WIN_CPU = 1'b0,
    WIN_DMA = 1'b1
  } winner_e;

endpackage

// File: rtl/dm_arbiter_if.sv
// Bundle of the CPU, DMA and DM-side signals around the data-memory arbiter.
// slave = the arbiter itself, master = the requesters plus the DM model.
interface dm_arbiter_if
  import dm_arbiter_pkg::*;
#(
  parameter int LEN_W  = 8,
  parameter int DMOP_W = DMOP_SIZE
);

  logic              cpu_req;
  logic [31:0]       cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [DMOP_W-1:0] cpu_op;
  logic              cpu_gnt;
  logic              cpu_stall;
  logic [31:0]       cpu_rdata;
  logic              cpu_rvalid;

  logic              dma_req;
  logic [31:0]       dma_addr;
  logic [31:0]       dma_wdata;
  logic [DMOP_W-1:0] dma_op;
  logic [LEN_W-1:0]  dma_len;
  logic              dma_gnt;
  logic [31:0]       dma_rdata;
  logic              dma_rvalid;
  logic              dma_done;

  logic [31:0]       dm_addr;
  logic [31:0]       dm_wdata;
  logic [DMOP_W-1:0] dm_op;
  logic [31:0]       dm_rdata;

  modport master (
    output cpu_req, cpu_addr, cpu_wdata, cpu_op,
    input  cpu_gnt, cpu_stall, cpu_rdata, cpu_rvalid,
    output dma_req, dma_addr, dma_wdata, dma_op, dma_len,
    input  dma_gnt, dma_rdata, dma_rvalid, dma_done,
    input  dm_addr, dm_wdata, dm_op,
    output dm_rdata
  );

  modport slave (
    input  cpu_req, cpu_addr, cpu_wdata, cpu_op,
    output cpu_gnt, cpu_stall, cpu_rdata, cpu_rvalid,
    input  dma_req, dma_addr, dma_wdata, dma_op, dma_len,
    output dma_gnt, dma_rdata, dma_rvalid, dma_done,
    output dm_addr, dm_wdata, dm_op,
    input  dm_rdata
  );

endinterface

// File: rtl/dm_arb_pick.sv
// Combinational grant picker for the DM arbiter. Tie policy: round-robin when
// DM_ARB_RR_EN is defined, otherwise fixed CPU priority.
module dm_arb_pick
  import dm_arbiter_pkg::*;
(
  input  logic    cpu_req,
  input  logic    dma_req,
  input  winner_e last_winner,
  input  logic    lock,
  output logic    cpu_gnt,
  output logic    dma_gnt
);

`ifndef DM_ARB_RR_EN
  // Fixed priority keeps last_winner on the port for a uniform interface.
  logic unused_last_winner;
  assign unused_last_winner = last_winner;
`endif

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    if (lock) begin
      dma_gnt = dma_req;
    end else if (cpu_req && dma_req) begin
`ifdef DM_ARB_RR_EN
      cpu_gnt = (last_winner == WIN_DMA);
      dma_gnt = (last_winner == WIN_CPU);
`else
      cpu_gnt = 1'b1;
`endif
    end else begin
      cpu_gnt = cpu_req;
      dma_gnt = dma_req;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Two-requester arbiter/sequencer sharing the single DM port between the CPU
// MEM stage and a DMA burst port. Optional round-robin ties: DM_ARB_RR_EN.
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int LEN_W  = 8,
  parameter int DMOP_W = DMOP_SIZE
)(
  input logic         clk,
  input logic         reset,
  dm_arbiter_if.slave bus
);

  logic [0:0]       state;
  logic [LEN_W-1:0] beats_left;
  logic [LEN_W-1:0] beat_idx;
  logic [31:0]      base;
  winner_e          last_winner;

  logic             lock;
  logic             cpu_req_g;
  logic             dma_req_g;
  logic             cpu_gnt;
  logic             dma_gnt;
  logic             single_beat;
  logic             last_beat;
  logic [31:0]      lock_addr;

  logic [31:0]       dm_addr;
  logic [31:0]       dm_wdata;
  logic [DMOP_W-1:0] dm_op;

  logic [31:0]      cpu_rdata;
  logic             cpu_rvalid;
  logic [31:0]      dma_rdata;
  logic             dma_rvalid;
  logic             dma_done;

  assign lock = (state == DMARB_LOCK);

  // Requests are masked while reset is high so grants and DM ops drop at once.
  assign cpu_req_g = bus.cpu_req & ~reset;
  assign dma_req_g = bus.dma_req & ~reset;

  dm_arb_pick u_pick (
    .cpu_req     (cpu_req_g),
    .dma_req     (dma_req_g),
    .last_winner (last_winner),
    .lock        (lock),
    .cpu_gnt     (cpu_gnt),
    .dma_gnt     (dma_gnt)
  );

  // A length of 0 or 1 is a single beat that never enters the lock state.
  assign single_beat = (bus.dma_len <= LEN_W'(1));
  assign last_beat   = lock ? (beats_left == LEN_W'(1)) : single_beat;
  assign lock_addr   = base + (32'(beat_idx) << 2);

  always_comb begin
    dm_addr  = '0;
    dm_wdata = '0;
    dm_op    = DMOP_W'(DMOP_NOP);
    if (cpu_gnt) begin
      dm_addr  = bus.cpu_addr;
      dm_wdata = bus.cpu_wdata;
      dm_op    = bus.cpu_op;
    end else if (dma_gnt) begin
      dm_addr  = lock ? lock_addr : bus.dma_addr;
      dm_wdata = bus.dma_wdata;
      dm_op    = bus.dma_op;
    end
  end

  // Burst sequencer and arbitration history.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset) begin
      state       <= DMARB_OPEN;
      beats_left  <= '0;
      beat_idx    <= '0;
      base        <= '0;
      last_winner <= WIN_DMA;
    end else if (!lock) begin
      if (cpu_gnt) begin
        last_winner <= WIN_CPU;
      end else if (dma_gnt) begin
        last_winner <= WIN_DMA;
        if (!single_beat) begin
          base       <= bus.dma_addr;
          beats_left <= bus.dma_len - LEN_W'(1);
          beat_idx   <= LEN_W'(1);
          state      <= DMARB_LOCK;
        end
      end
    end else if (dma_gnt) begin
      beat_idx   <= beat_idx + LEN_W'(1);
      beats_left <= beats_left - LEN_W'(1);
      if (beats_left == LEN_W'(1)) begin
        state       <= DMARB_OPEN;
        last_winner <= WIN_DMA;
      end
    end
  end

  // Read return: only the winner of a read captures DM data; the loser holds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_rdata  <= '0;
      cpu_rvalid <= 1'b0;
      dma_rdata  <= '0;
      dma_rvalid <= 1'b0;
      dma_done   <= 1'b0;
    end else begin
      cpu_rvalid <= cpu_gnt & ~bus.cpu_op[0];
      dma_rvalid <= dma_gnt & ~bus.dma_op[0];
      dma_done   <= dma_gnt & last_beat;
      if (cpu_gnt && !bus.cpu_op[0]) cpu_rdata <= bus.dm_rdata;
      if (dma_gnt && !bus.dma_op[0]) dma_rdata <= bus.dm_rdata;
    end
  end

  assign bus.cpu_gnt    = cpu_gnt;
  assign bus.cpu_stall  = bus.cpu_req & ~cpu_gnt;
  assign bus.cpu_rdata  = cpu_rdata;
  assign bus.cpu_rvalid = cpu_rvalid;
  assign bus.dma_gnt    = dma_gnt;
  assign bus.dma_rdata  = dma_rdata;
  assign bus.dma_rvalid = dma_rvalid;
  assign bus.dma_done   = dma_done;
  assign bus.dm_addr    = dm_addr;
  assign bus.dm_wdata   = dm_wdata;
  assign bus.dm_op      = dm_op;

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter: expected DM writes and read returns are
// queued as stimulus is driven and retired by a negedge monitor.
module tb_dm_arbiter;
  import dm_arbiter_pkg::*;

  localparam int LEN_W  = 8;
  localparam int DMOP_W = DMOP_SIZE;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dm_arbiter_if #(.LEN_W(LEN_W), .DMOP_W(DMOP_W)) bus ();

  dm_arbiter #(.LEN_W(LEN_W), .DMOP_W(DMOP_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         wr_q[$];
  logic [31:0] cpu_q[$];
  logic [31:0] dma_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;

  // DM model: unwritten words return a fixed pattern, word 4 holds DEADBEEF.
  logic [31:0] wmem    [0:1023];
  bit          written [0:1023];

  function automatic logic [31:0] init_word(input logic [9:0] i);
    return (i == 10'd4) ? 32'hDEAD_BEEF : (32'hA500_0000 | {22'd0, i});
  endfunction

  assign bus.dm_rdata = written[bus.dm_addr[11:2]] ? wmem[bus.dm_addr[11:2]]
                                                   : init_word(bus.dm_addr[11:2]);

  always @(posedge clk) begin
    if (bus.dm_op[0]) begin
      wmem[bus.dm_addr[11:2]]    <= bus.dm_wdata;
      written[bus.dm_addr[11:2]] <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (bus.dm_op[0]) begin
      if (wr_q.size() == 0) check("wr_unexpected", 32'(bus.dm_addr), 32'hFFFF_FFFF);
      else begin
        e = wr_q.pop_front();
        check("wr_addr", bus.dm_addr, e.addr);
        check("wr_data", bus.dm_wdata, e.data);
      end
    end
    if (bus.cpu_rvalid) begin
      if (cpu_q.size() == 0) check("cpu_rvalid_unexpected", 32'(bus.cpu_rdata), 32'hFFFF_FFFF);
      else check("cpu_rdata", bus.cpu_rdata, cpu_q.pop_front());
    end
    if (bus.dma_rvalid) begin
      if (dma_q.size() == 0) check("dma_rvalid_unexpected", 32'(bus.dma_rdata), 32'hFFFF_FFFF);
      else check("dma_rdata", bus.dma_rdata, dma_q.pop_front());
    end
    if (bus.dma_done) done_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cpu(input logic req, input logic [31:0] addr,
                           input logic [DMOP_W-1:0] op, input logic [31:0] wdata);
    bus.cpu_req   = req;
    bus.cpu_addr  = addr;
    bus.cpu_op    = op;
    bus.cpu_wdata = wdata;
  endtask

  task automatic drive_dma(input logic req, input logic [31:0] addr,
                           input logic [DMOP_W-1:0] op, input logic [31:0] wdata,
                           input logic [LEN_W-1:0] len);
    bus.dma_req   = req;
    bus.dma_addr  = addr;
    bus.dma_op    = op;
    bus.dma_wdata = wdata;
    bus.dma_len   = len;
  endtask

  task automatic push_wr(input logic [31:0] addr, input logic [31:0] data);
    wr_t e;
    e.addr = addr;
    e.data = data;
    wr_q.push_back(e);
  endtask

  initial begin
    // Reset: both requesters asserted, nothing may be granted or driven.
    drive_cpu(1'b1, 32'h10, DMOP_SW, 32'h1111);
    drive_dma(1'b1, 32'h20, DMOP_SW, 32'h2222, 8'd4);
    #2;
    check("rst_cpu_gnt", 32'(bus.cpu_gnt), 0);
    check("rst_dma_gnt", 32'(bus.dma_gnt), 0);
    check("rst_dm_op",   32'(bus.dm_op), 32'(DMOP_NOP));
    check("rst_rvalid",  32'({bus.cpu_rvalid, bus.dma_rvalid, bus.dma_done}), 0);
    check("rst_rdata",   bus.cpu_rdata | bus.dma_rdata, 0);
    step();
    step();
    drive_cpu(1'b0, 32'h0, DMOP_NOP, 32'h0);
    drive_dma(1'b0, 32'h0, DMOP_NOP, 32'h0, 8'd0);
    reset = 1'b0;
    step();

    // First tie after reset: the CPU wins either way.
    drive_cpu(1'b1, 32'h10, DMOP_LW, 32'h0);
    drive_dma(1'b1, 32'h20, DMOP_LW, 32'h0, 8'd1);
    #1;
    check("tie1_cpu_gnt", 32'(bus.cpu_gnt), 1);
    check("tie1_dma_gnt", 32'(bus.dma_gnt), 0);
    cpu_q.push_back(32'hDEAD_BEEF);
    step();
    drive_cpu(1'b1, 32'h14, DMOP_LW, 32'h0);
    #1;
`ifdef DM_ARB_RR_EN
    check("tie2_dma_gnt", 32'(bus.dma_gnt), 1);
    check("tie2_cpu_stall", 32'(bus.cpu_stall), 1);
    dma_q.push_back(32'hA500_0008);
    step();
    drive_dma(1'b0, 32'h0, DMOP_NOP, 32'h0, 8'd0);
    #1;
    check("tie3_cpu_gnt", 32'(bus.cpu_gnt), 1);
    check("tie_dma_done", 32'(bus.dma_done), 1);
    cpu_q.push_back(32'hA500_0005);
    step();
    drive_cpu(1'b0, 32'h0, DMOP_NOP, 32'h0);
`else
    check("tie2_cpu_gnt", 32'(bus.cpu_gnt), 1);
    check("tie2_dma_gnt", 32'(bus.dma_gnt), 0);
    cpu_q.push_back(32'hA500_0005);
    step();
    drive_cpu(1'b0, 32'h0, DMOP_NOP, 32'h0);
    #1;
    check("tie3_dma_gnt", 32'(bus.dma_gnt), 1);
    dma_q.push_back(32'hA500_0008);
    step();
    drive_dma(1'b0, 32'h0, DMOP_NOP, 32'h0, 8'd0);
    #1;
    check("tie_dma_done", 32'(bus.dma_done), 1);
`endif
    step();

    // CPU alone: zero-latency grant, data one cycle later.
    drive_cpu(1'b1, 32'h10, DMOP_LW, 32'h0);
    #1;
    check("cpu_gnt", 32'(bus.cpu_gnt), 1);
    check("cpu_stall", 32'(bus.cpu_stall), 0);
    cpu_q.push_back(32'hDEAD_BEEF);
    step();
    drive_cpu(1'b0, 32'h0, DMOP_NOP, 32'h0);
    check("cpu_rvalid", 32'(bus.cpu_rvalid), 1);
    step();
    check("cpu_rvalid_pulse", 32'(bus.cpu_rvalid), 0);

    // Write burst of 4 at 0x100; CPU requests from beat 2 and must stall.
    drive_dma(1'b1, 32'h100, DMOP_SW, 32'd1, 8'd4);
    push_wr(32'h100, 32'd1);
    #1;
    check("bw_beat1_gnt", 32'(bus.dma_gnt), 1);
    for (int b = 2; b <= 4; b++) begin
      step();
      drive_dma(1'b1, 32'hBAD0, DMOP_SW, 32'(b), 8'd9);
      if (b == 2) drive_cpu(1'b1, 32'h10, DMOP_LW, 32'h0);
      push_wr(32'h100 + 32'(4 * (b - 1)), 32'(b));
      #1;
      check("bw_cpu_stall", 32'({bus.cpu_gnt, bus.cpu_stall, bus.dma_gnt}), 32'b011);
      check("bw_no_done", 32'(bus.dma_done), 0);
    end
    step();
    drive_dma(1'b0, 32'h0, DMOP_NOP, 32'h0, 8'd0);
    #1;
    check("bw_done", 32'(bus.dma_done), 1);
    check("bw_cpu_after", 32'(bus.cpu_gnt), 1);
    cpu_q.push_back(32'hDEAD_BEEF);
    step();
    drive_cpu(1'b0, 32'h0, DMOP_NOP, 32'h0);
    check("bw_done_pulse", 32'(bus.dma_done), 0);

    // Read the burst back; done coincides with the last read return.
    drive_dma(1'b1, 32'h100, DMOP_LW, 32'h0, 8'd4);
    for (int b = 1; b <= 4; b++) begin
      dma_q.push_back(32'(b));
      step();
    end
    drive_dma(1'b0, 32'h0, DMOP_NOP, 32'h0, 8'd0);
    check("br_done_rvalid", 32'({bus.dma_done, bus.dma_rvalid}), 32'b11);
    step();

    // Burst with a two-cycle gap after beat 2; CPU held off throughout.
    begin
      logic [5:0] pat;
      int beat;
      pat  = 6'b110011;
      beat = 0;
      for (int c = 0; c < 6; c++) begin
        if (pat[5 - c]) begin
          drive_dma(1'b1, 32'h200, DMOP_SW, 32'(11 + beat), 8'd4);
          push_wr(32'h200 + 32'(4 * beat), 32'(11 + beat));
          beat++;
        end else begin
          drive_dma(1'b0, 32'h0, DMOP_SW, 32'h0, 8'd0);
          drive_cpu(1'b1, 32'h10, DMOP_LW, 32'h0);
        end
        #1;
        if (!pat[5 - c]) check("gap_nop", 32'({bus.dm_op, bus.cpu_gnt, bus.dma_gnt}), 0);
        step();
      end
    end
    drive_dma(1'b0, 32'h0, DMOP_NOP, 32'h0, 8'd0);
    #1;
    check("gap_done", 32'(bus.dma_done), 1);
    check("gap_cpu_after", 32'(bus.cpu_gnt), 1);
    cpu_q.push_back(32'hDEAD_BEEF);
    step();
    drive_cpu(1'b0, 32'h0, DMOP_NOP, 32'h0);

    // Address wrap across 2^32.
    drive_dma(1'b1, 32'hFFFF_FFFC, DMOP_SW, 32'h77, 8'd2);
    push_wr(32'hFFFF_FFFC, 32'h77);
    step();
    drive_dma(1'b1, 32'h5555, DMOP_SW, 32'h88, 8'd2);
    push_wr(32'h0, 32'h88);
    #1;
    check("wrap_addr", bus.dm_addr, 32'h0);
    step();
    drive_dma(1'b0, 32'h0, DMOP_NOP, 32'h0, 8'd0);
    check("wrap_done", 32'(bus.dma_done), 1);
    step();

    // len = 0 is a single beat; the CPU is free the very next cycle.
    drive_dma(1'b1, 32'h300, DMOP_SW, 32'h99, 8'd0);
    push_wr(32'h300, 32'h99);
    #1;
    check("len0_gnt", 32'(bus.dma_gnt), 1);
    step();
    drive_dma(1'b0, 32'h0, DMOP_NOP, 32'h0, 8'd0);
    drive_cpu(1'b1, 32'h14, DMOP_LW, 32'h0);
    #1;
    check("len0_done", 32'(bus.dma_done), 1);
    check("len0_open", 32'(bus.cpu_gnt), 1);
    cpu_q.push_back(32'hA500_0005);
    step();
    drive_cpu(1'b0, 32'h0, DMOP_NOP, 32'h0);
    step();

    // Async reset during beat 3 of an 8-beat burst.
    drive_dma(1'b1, 32'h400, DMOP_SW, 32'h41, 8'd8);
    push_wr(32'h400, 32'h41);
    step();
    drive_dma(1'b1, 32'h0, DMOP_SW, 32'h42, 8'd8);
    push_wr(32'h404, 32'h42);
    step();
    drive_dma(1'b1, 32'h0, DMOP_SW, 32'h43, 8'd8);
    #1;
    check("rst3_addr", bus.dm_addr, 32'h408);
    reset = 1'b1;
    #1;
    check("rst3_gnt_drop", 32'({bus.dma_gnt, bus.dm_op}), 0);
    check("rst3_rdata", bus.cpu_rdata | bus.dma_rdata, 0);
    step();
    check("rst3_held", 32'({bus.dma_gnt, bus.dma_done, bus.dma_rvalid}), 0);
    drive_dma(1'b0, 32'h0, DMOP_NOP, 32'h0, 8'd0);
    reset = 1'b0;
    step();
    drive_cpu(1'b1, 32'h10, DMOP_LW, 32'h0);
    #1;
    check("rst3_cpu_gnt", 32'(bus.cpu_gnt), 1);
    check("rst3_no_done", 32'(bus.dma_done), 0);
    cpu_q.push_back(32'hDEAD_BEEF);
    step();
    drive_cpu(1'b0, 32'h0, DMOP_NOP, 32'h0);
    repeat (3) step();

    check("wr_q_empty",  32'(wr_q.size()), 0);
    check("cpu_q_empty", 32'(cpu_q.size()), 0);
    check("dma_q_empty", 32'(dma_q.size()), 0);
    check("done_count",  32'(done_cnt), 6);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-requester arbiter and sequencer in front of the data memory (DM). Shares the single DM port between the CPU MEM-stage load/store path and a DMA/loader port that issues multi-word bursts. The block:
- selects a winner each cycle and drives the DM address, write data and operation;
- registers read data back to the winner;
- generates the CPU stall condition.

## Interface
Parameters:
- `LEN_W`, default 8: width of the DMA burst-length field.
- `DMOP_W`, default `` `DMOP_SIZE ``: DM operation width. `op[0]` is write enable; `op[3:1]` selects width (word/byte/half/byteu/halfu).

Ports:
- `clk`  in  1  the single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high.
- `cpu_req`  in  1  CPU access request, level, held until granted.
- `cpu_addr`  in  32  CPU byte address.
- `cpu_wdata`  in  32  CPU store data (raw, unaligned lanes as DM expects).
- `cpu_op`  in  DMOP_W  CPU DM operation.
- `cpu_gnt`  out  1  CPU access performed this cycle (combinational).
- `cpu_stall`  out  1  `cpu_req & ~cpu_gnt`.
- `cpu_rdata`  out  32  registered load data.
- `cpu_rvalid`  out  1  one-cycle pulse: `cpu_rdata` is valid.
- `dma_req`  in  1  DMA beat request, level.
- `dma_addr`  in  32  burst base byte address, sampled on first beat only.
- `dma_wdata`  in  32  write data for the current beat.
- `dma_op`  in  DMOP_W  DMA operation. Bursts longer than one beat must use word width.
- `dma_len`  in  LEN_W  beats in the burst, sampled on first beat; 0 is treated as 1.
- `dma_gnt`  out  1  DMA beat performed this cycle (combinational).
- `dma_rdata`  out  32  registered read data.
- `dma_rvalid`  out  1  one-cycle pulse: `dma_rdata` is valid.
- `dma_done`  out  1  one-cycle pulse, cycle after the last beat is accepted.
- `dm_addr`  out  32  to DM.
- `dm_wdata`  out  32  to DM.
- `dm_op`  out  DMOP_W  to DM; `` `DMOP_NOP `` (all zeros, no write) when idle.
- `dm_rdata`  in  32  combinational read data from DM.

## Operation
- FSM states are OPEN and DMA_LOCK.
- **OPEN:**
  - The picker chooses among the asserted requests; at most one grant per cycle.
  - When a DMA beat is granted and the effective length is greater than 1:
    - capture `base = dma_addr`;
    - set `beats_left = len-1` and `beat_idx = 1`;
    - go to DMA_LOCK.
  - When a single-beat DMA is granted, stay in OPEN.
- **DMA_LOCK:**
  - The CPU is never granted.
  - `dma_gnt = dma_req`. `dm_addr = base + 4*beat_idx`, modulo 2^32 (wraps silently).
  - If `dma_req` is low, the cycle is a bubble: `dm_op = NOP`, counters hold.
  - On each accepted beat, `beat_idx++` and `beats_left--`. When the beat with `beats_left==1` is accepted, return to OPEN.
- **Mux:**
  - `dm_addr`, `dm_wdata` and `dm_op` come from the granted requester.
  - With no grant: `dm_op = NOP`, and addr/wdata are 0.
- **Read return:**
  - A granted access with `op[0]==0` registers `dm_rdata` into the winner's `rdata`.
  - The winner's `rvalid` pulses on the next cycle.
  - The loser's `rdata` holds its old value.
- **Writes** are performed by DM at the same edge that ends the grant cycle.
- **`last_winner`** register: updated on every OPEN-state grant, and on burst completion (set to DMA).

## Timing
- Grant and DM drive happen in the same cycle as the request (zero-latency grant). Read data arrives 1 cycle later.
- A burst of N beats with `dma_req` held high occupies N consecutive cycles.
- `dma_done` asserts at cycle N+1 (relative to the first beat at cycle 1), concurrent with the final `dma_rvalid` for a read burst.
- Simultaneous requests in OPEN are resolved per Configuration. A CPU request arriving during DMA_LOCK stalls until the burst ends; the CPU is granted in the first OPEN cycle when `dma_req` is low or when the CPU wins arbitration.
- Reset values:
  - FSM = OPEN, `beats_left` = 0, `beat_idx` = 0, `base` = 0;
  - both `rdata` = 0, both `rvalid` = 0, `dma_done` = 0, `last_winner` = DMA;
  - `cpu_gnt`/`dma_gnt` are forced 0 and `dm_op` = NOP while `reset` is high.
- Reset mid-burst aborts immediately: no `dma_done`, and no further writes.

## Configuration
- `DM_ARB_RR_EN` defined: round-robin. On a tie the requester that is not `last_winner` wins, so the CPU wins the first tie after reset.
- Undefined: fixed priority, CPU always wins ties. `last_winner` is still maintained but unused.
- DMA_LOCK behaviour is identical in both modes.

## Structure
- Shared header `macros.v`:
  - `` `DMOP_SIZE `` and the `` `DMOP_* `` width codes;
  - new `` `DMOP_NOP `` (all zeros);
  - state codes `` `DMARB_OPEN `` and `` `DMARB_LOCK ``.
- One sub-module, `dm_arb_pick`. It is combinational and takes the two requests, `last_winner` and lock; it outputs the two grants. The `DM_ARB_RR_EN` selection lives only here.

## Test plan
- CPU alone: `cpu_req`, lw from `0x10` with DM holding `0xDEADBEEF` → `cpu_gnt` same cycle, `cpu_stall`=0, next cycle `cpu_rvalid`=1 and `cpu_rdata`=`0xDEADBEEF`.
- Tie at first cycle after reset, both single-beat → CPU granted and DMA waits one cycle. A second tie with `DM_ARB_RR_EN` → DMA wins. Without the macro → CPU wins again.
- DMA write burst, `len`=4, base `0x100`, data 1..4, `cpu_req` asserted mid-burst → DM words `0x100`–`0x10C` = 1..4, CPU stalled for the remaining beats, `dma_done` pulses once at cycle 5.
- Burst with `dma_req` dropped on beat 2 for 2 cycles → `dm_op`=NOP in gap cycles, beats resume at `base+8`, total 4 writes.
- Wrap: base `0xFFFFFFFC`, `len`=2 → second beat address `0x00000000`. Separately `len`=0 → single beat and stays OPEN.
- Async reset asserted during beat 3 of a `len`=8 burst → grants drop immediately, FSM OPEN, no `dma_done`, next CPU request granted the cycle after reset deasserts.
